// File: rtl/tetris_pkg.sv
// Shared Tetris types: shape codes, widths, queue occupancy states.
// Used by the randomiser, piece_queue and the game FSM.
package tetris_pkg;

  localparam int SHAPE_W    = 3;
  localparam int NUM_SHAPES = 7;

  typedef logic [SHAPE_W-1:0] shape_t;

  localparam shape_t SHAPE_NONE = 3'd7;

  typedef enum logic [SHAPE_W-1:0] {
    SH_I    = 3'd0,
    SH_O    = 3'd1,
    SH_T    = 3'd2,
    SH_S    = 3'd3,
    SH_Z    = 3'd4,
    SH_J    = 3'd5,
    SH_L    = 3'd6,
    SH_NONE = 3'd7
  } shape_e;

  typedef enum logic [1:0] {
    Q_EMPTY,
    Q_FILLING,
    Q_FULL
  } q_state_e;

  // One-hot shape bit; SHAPE_NONE shifts out and yields zero.
  function automatic logic [NUM_SHAPES-1:0] shape_bit(
    input shape_t s
  );
    logic [NUM_SHAPES:0] w;
    w = (NUM_SHAPES+1)'(1) << s;
    return w[NUM_SHAPES-1:0];
  endfunction

endpackage

// File: rtl/piece_queue_if.sv
// Randomiser/FSM side of the piece queue: shape in, pop req, previews out.
// master = driver of rand_id/req, slave = the queue itself.
interface piece_queue_if
  import tetris_pkg::*;
#(
  parameter int DEPTH = 3
) ();

  shape_t                  rand_id;
  logic                    req;
  logic                    piece_valid;
  shape_t                  piece_id;
  logic [3*DEPTH-1:0]      preview_ids;
  logic [2:0]              count;
  logic [NUM_SHAPES-1:0]   bag_mask;

  modport master (
    output rand_id,
    output req,
    input  piece_valid,
    input  piece_id,
    input  preview_ids,
    input  count,
    input  bag_mask
  );

  modport slave (
    input  rand_id,
    input  req,
    output piece_valid,
    output piece_id,
    output preview_ids,
    output count,
    output bag_mask
  );

endinterface

// File: rtl/piece_bag_filter.sv
// Shape legality check plus the 7-bag "already dealt" mask.
// Ports: clock/reset, rand_id_i, push_i (accepted push), legal_o, bag_mask_o.
module piece_bag_filter
  import tetris_pkg::*;
#(
  parameter int BAG_MODE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  shape_t                rand_id_i,
  input  logic                  push_i,
  output logic                  legal_o,
  output logic [NUM_SHAPES-1:0] bag_mask_o
);

  logic [NUM_SHAPES-1:0] bag_q;
  logic [NUM_SHAPES-1:0] bag_d;
  logic [NUM_SHAPES-1:0] id_bit;
  logic [NUM_SHAPES-1:0] bag_or;
  logic                  dealt;

  assign id_bit = shape_bit(rand_id_i);
  assign dealt  = (BAG_MODE != 0) && ((bag_q & id_bit) != '0);

  assign legal_o    = (rand_id_i != SHAPE_NONE) && !dealt;
  assign bag_mask_o = bag_q;

  assign bag_or = bag_q | id_bit;

  // Completing the bag clears it on the same edge.
  always_comb begin
    bag_d = bag_q;
    if ((BAG_MODE != 0) && push_i) begin
      if (bag_or == '1) begin
        bag_d = '0;
      end else begin
        bag_d = bag_or;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bag_q <= '0;
    end else begin
      bag_q <= bag_d;
    end
  end

endmodule

// File: rtl/piece_queue.sv
// Shift-register preview queue of upcoming Tetris pieces.
// Ports: clock, reset, q (slave: rand_id/req in; head, previews, count, bag out).
module piece_queue
  import tetris_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int BAG_MODE = 1
) (
  input  logic          clock,
  input  logic          reset,
  piece_queue_if.slave  q
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  shape_t             slots_q [DEPTH];
  shape_t             slots_d [DEPTH];
  logic [2:0]         cnt_q;
  logic [2:0]         cnt_d;
  logic               valid_q;
  logic               valid_d;
  logic [3*DEPTH-1:0] preview;

  q_state_e           state;
  logic               legal;
  logic               pop;
  logic               push;
  logic [2:0]         wr_idx;

  piece_bag_filter #(
    .BAG_MODE (BAG_MODE)
  ) u_bag (
    .clock      (clock),
    .reset      (reset),
    .rand_id_i  (q.rand_id),
    .push_i     (push),
    .legal_o    (legal),
    .bag_mask_o (q.bag_mask)
  );

  // Occupancy state is a pure decode of the count.
  always_comb begin
    state = Q_FILLING;
    unique case (1'b1)
      (cnt_q == 3'd0):    state = Q_EMPTY;
      (cnt_q == DEPTH_C): state = Q_FULL;
      default:            state = Q_FILLING;
    endcase
  end

  assign pop  = q.req && (state != Q_EMPTY);
  assign push = legal && ((state != Q_FULL) || q.req);

  // After a pop the append slot moves down by one.
  assign wr_idx = pop ? (cnt_q - 3'd1) : cnt_q;

  always_comb begin
    slots_d = slots_q;
    if (pop) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        slots_d[k] = slots_q[k+1];
      end
      slots_d[DEPTH-1] = SHAPE_NONE;
    end
    if (push) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (3'(k) == wr_idx) begin
          slots_d[k] = q.rand_id;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign valid_d = (cnt_d != 3'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        slots_q[k] <= SHAPE_NONE;
      end
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    preview = '1;
    for (int k = 0; k < DEPTH; k++) begin
      preview[3*k +: 3] = slots_q[k];
    end
  end

  assign q.preview_ids = preview;
  assign q.piece_id    = slots_q[0];
  assign q.count       = cnt_q;
  assign q.piece_valid = valid_q;

endmodule

// File: tb/tb_piece_queue.sv
// Bench for piece_queue: four configurations share one stimulus stream.
// Directed table, hand sequences, then random traffic vs a queue model.
module tb_piece_queue;
  import tetris_pkg::*;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rid   = 3'd7;
  logic       req   = 1'b0;

  always #5 clock = ~clock;

  piece_queue_if #(.DEPTH(3)) ifa ();
  piece_queue_if #(.DEPTH(3)) ifb ();
  piece_queue_if #(.DEPTH(6)) ifc ();
  piece_queue_if #(.DEPTH(1)) ifd ();

  assign ifa.rand_id = rid;
  assign ifb.rand_id = rid;
  assign ifc.rand_id = rid;
  assign ifd.rand_id = rid;
  assign ifa.req = req;
  assign ifb.req = req;
  assign ifc.req = req;
  assign ifd.req = req;

  piece_queue #(.DEPTH(3), .BAG_MODE(0)) ua (
    .clock(clock), .reset(reset), .q(ifa.slave));
  piece_queue #(.DEPTH(3), .BAG_MODE(1)) ub (
    .clock(clock), .reset(reset), .q(ifb.slave));
  piece_queue #(.DEPTH(6), .BAG_MODE(1)) uc (
    .clock(clock), .reset(reset), .q(ifc.slave));
  piece_queue #(.DEPTH(1), .BAG_MODE(0)) ud (
    .clock(clock), .reset(reset), .q(ifd.slave));

  int checks = 0;
  int errors = 0;

  int mq [N][$];
  int mbag [N];
  int mdep [N] = '{3, 3, 6, 1};
  int mbm  [N] = '{0, 1, 1, 0};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: a bounded list of pieces and a set of dealt shapes.
  task automatic model_step(input logic r, input int id, input logic rq);
    for (int i = 0; i < N; i++) begin
      if (r) begin
        mq[i].delete();
        mbag[i] = 0;
      end else begin
        bit legal;
        legal = (id != 7) && (mbm[i] == 0 || mbag[i][id] == 0);
        if (rq && mq[i].size() > 0) void'(mq[i].pop_front());
        if (legal && mq[i].size() < mdep[i]) begin
          mq[i].push_back(id);
          if (mbm[i] != 0) begin
            mbag[i] = mbag[i] | (1 << id);
            if (mbag[i] == 127) mbag[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic chk_inst(input int i, input logic [2:0] cnt,
                          input logic v, input logic [2:0] pid,
                          input logic [17:0] prev, input logic [6:0] bag);
    logic [17:0] ep;
    int sz;
    sz = mq[i].size();
    ep = '0;
    for (int k = 0; k < mdep[i]; k++) begin
      ep = ep | (18'(k < sz ? mq[i][k] : 7) << (3*k));
    end
    chk($sformatf("m%0d.count", i), 32'(cnt), 32'(sz));
    chk($sformatf("m%0d.valid", i), 32'(v), 32'(sz != 0));
    chk($sformatf("m%0d.piece_id", i), 32'(pid),
        32'(sz != 0 ? mq[i][0] : 7));
    chk($sformatf("m%0d.preview", i), 32'(prev), 32'(ep));
    chk($sformatf("m%0d.bag", i), 32'(bag), 32'(mbag[i]));
  endtask

  task automatic check_all();
    chk_inst(0, ifa.count, ifa.piece_valid, ifa.piece_id,
             18'(ifa.preview_ids), ifa.bag_mask);
    chk_inst(1, ifb.count, ifb.piece_valid, ifb.piece_id,
             18'(ifb.preview_ids), ifb.bag_mask);
    chk_inst(2, ifc.count, ifc.piece_valid, ifc.piece_id,
             18'(ifc.preview_ids), ifc.bag_mask);
    chk_inst(3, ifd.count, ifd.piece_valid, ifd.piece_id,
             18'(ifd.preview_ids), ifd.bag_mask);
  endtask

  task automatic tick(input logic r, input logic [2:0] id,
                      input logic rq);
    reset = r;
    rid   = id;
    req   = rq;
    @(posedge clock);
    model_step(r, int'(id), rq);
    #1;
    check_all();
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] rid;
    logic       req;
    logic [2:0] a_cnt;
    logic [8:0] a_prev;
    logic [2:0] b_cnt;
    logic [6:0] b_bag;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{1'b1, 3'd3, 1'b0, 3'd0, 9'h1FF, 3'd0, 7'h00};
    vt[1] = '{1'b0, 3'd3, 1'b0, 3'd1, 9'h1FB, 3'd1, 7'h08};
    vt[2] = '{1'b0, 3'd3, 1'b0, 3'd2, 9'h1DB, 3'd1, 7'h08};
    vt[3] = '{1'b0, 3'd3, 1'b0, 3'd3, 9'h0DB, 3'd1, 7'h08};
    vt[4] = '{1'b0, 3'd3, 1'b0, 3'd3, 9'h0DB, 3'd1, 7'h08};
    vt[5] = '{1'b0, 3'd7, 1'b1, 3'd2, 9'h1DB, 3'd0, 7'h08};
    vt[6] = '{1'b0, 3'd7, 1'b1, 3'd1, 9'h1FB, 3'd0, 7'h08};
    vt[7] = '{1'b0, 3'd7, 1'b0, 3'd1, 9'h1FB, 3'd0, 7'h08};

    for (int i = 0; i < 8; i++) begin
      tick(vt[i].rst, vt[i].rid, vt[i].req);
      chk($sformatf("vec%0d.a_cnt", i), 32'(ifa.count),
          32'(vt[i].a_cnt));
      chk($sformatf("vec%0d.a_prev", i), 32'(ifa.preview_ids),
          32'(vt[i].a_prev));
      chk($sformatf("vec%0d.a_valid", i), 32'(ifa.piece_valid),
          32'(vt[i].a_cnt != 0));
      chk($sformatf("vec%0d.a_head", i), 32'(ifa.piece_id),
          32'(vt[i].a_prev[2:0]));
      chk($sformatf("vec%0d.b_cnt", i), 32'(ifb.count),
          32'(vt[i].b_cnt));
      chk($sformatf("vec%0d.b_bag", i), 32'(ifb.bag_mask),
          32'(vt[i].b_bag));
    end

    // Idle randomiser: nothing ever enters.
    tick(1'b1, 3'd7, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 3'd7, 1'b0);
    chk("idle.count", 32'(ifa.count), 32'd0);
    chk("idle.valid", 32'(ifa.piece_valid), 32'd0);
    chk("idle.prev", 32'(ifa.preview_ids), 32'h1FF);

    // Pop on empty is ignored.
    tick(1'b0, 3'd7, 1'b1);
    chk("empty_pop.count", 32'(ifa.count), 32'd0);
    chk("empty_pop.head", 32'(ifa.piece_id), 32'd7);

    // Reset in the middle of filling.
    tick(1'b0, 3'd2, 1'b0);
    tick(1'b0, 3'd4, 1'b0);
    chk("midfill.count", 32'(ifa.count), 32'd2);
    chk("midfill.bag", 32'(ifb.bag_mask), 32'h14);
    tick(1'b1, 3'd5, 1'b0);
    chk("rst.count", 32'(ifa.count), 32'd0);
    chk("rst.bag", 32'(ifb.bag_mask), 32'h00);
    chk("rst.head", 32'(ifa.piece_id), 32'd7);

    // Full {1,2,4}, pop-and-push with a legal code.
    tick(1'b0, 3'd1, 1'b0);
    tick(1'b0, 3'd2, 1'b0);
    tick(1'b0, 3'd4, 1'b0);
    chk("pp.head_before", 32'(ifa.piece_id), 32'd1);
    tick(1'b0, 3'd5, 1'b1);
    chk("pp.prev", 32'(ifa.preview_ids), 32'h162);
    chk("pp.count", 32'(ifa.count), 32'd3);

    // Same start, pop with no shape available.
    tick(1'b1, 3'd7, 1'b0);
    tick(1'b0, 3'd1, 1'b0);
    tick(1'b0, 3'd2, 1'b0);
    tick(1'b0, 3'd4, 1'b0);
    tick(1'b0, 3'd7, 1'b1);
    chk("pop7.prev", 32'(ifa.preview_ids), 32'h1E2);
    chk("pop7.count", 32'(ifa.count), 32'd2);

    // Deep bag-mode queue: deal a whole bag while popping.
    tick(1'b1, 3'd7, 1'b0);
    for (int s = 0; s < 7; s++) begin
      tick(1'b0, 3'(s), 1'b1);
      chk($sformatf("bag.mask%0d", s), 32'(ifc.bag_mask),
          s < 6 ? ((32'd1 << (s + 1)) - 1) : 32'd0);
      chk($sformatf("bag.head%0d", s), 32'(ifc.piece_id), 32'(s));
      chk($sformatf("bag.count%0d", s), 32'(ifc.count), 32'd1);
    end
    tick(1'b0, 3'd0, 1'b1);
    chk("bag.new", 32'(ifc.bag_mask), 32'h01);

    // Single-slot queue keeps its piece valid across pop-and-push.
    tick(1'b1, 3'd7, 1'b0);
    tick(1'b0, 3'd1, 1'b0);
    for (int s = 2; s < 8; s++) begin
      tick(1'b0, 3'(s % 7), 1'b1);
      chk($sformatf("d1.valid%0d", s), 32'(ifd.piece_valid), 32'd1);
      chk($sformatf("d1.head%0d", s), 32'(ifd.piece_id), 32'(s % 7));
    end

    // Random traffic, occasional resets and req bursts.
    for (int i = 0; i < 4000; i++) begin
      logic r;
      logic q;
      r = ($urandom_range(0, 199) == 0);
      q = ($urandom_range(0, 3) == 0) ||
          (((i / 64) % 3 == 1) && ($urandom_range(0, 3) != 0));
      tick(r, 3'($urandom_range(0, 7)), q);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
